// File: rtl/sram_sync_param_if.sv
// Access bus for sram_sync_param: request fields from the master, read data,
// strobes and sweep status back from the RAM.
interface sram_sync_param_if #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 5
);
    logic              en;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic              clr;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              busy;
    logic              err;

    modport master (
        output en, we, addr, din, clr,
        input  dout, dout_valid, busy, err
    );

    modport slave (
        input  en, we, addr, din, clr,
        output dout, dout_valid, busy, err
    );
endinterface

// File: rtl/sram_sync_param.sv
// Single-port synchronous RAM with a clear sweeper, read-valid strobe and range error.
// Define SRAM_OUT_REG_EN to add an output register stage (dout/dout_valid/err latency 2).
module sram_sync_param #(
    parameter int                DATA_W   = 4,
    parameter int                ADDR_W   = 5,
    parameter int                DEPTH    = 32,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input logic               clk,
    input logic               rst,
    sram_sync_param_if.slave  bus
);
    localparam logic [0:0]        S_CLEAR  = 1'b0;
    localparam logic [0:0]        S_IDLE   = 1'b1;
    localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    if (DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_bad_depth
        $error("sram_sync_param: DEPTH must be in 1..2**ADDR_W");
    end

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_ptr;

    logic              w_idle;
    logic              w_acc;
    logic              w_in_range;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;

    assign w_idle     = (r_state == S_IDLE);
    // clr outranks en on the same edge
    assign w_acc      = w_idle && !bus.clr && bus.en;
    assign w_in_range = ({1'b0, bus.addr} < DEPTH_W);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_CLEAR;
            r_ptr   <= '0;
        end else if (r_state == S_CLEAR) begin
            // terminate on DEPTH-1, not on wrap, so odd depths work
            if (r_ptr == LAST_PTR) begin
                r_state <= S_IDLE;
            end
            r_ptr <= r_ptr + ADDR_W'(1);
        end else if (bus.clr) begin
            r_state <= S_CLEAR;
            r_ptr   <= '0;
        end
    end

    always_comb begin
        w_mem_we = 1'b0;
        w_waddr  = r_ptr;
        w_wdata  = INIT_VAL;
        if (!rst) begin
            if (!w_idle) begin
                w_mem_we = 1'b1;
            end else if (w_acc && bus.we && w_in_range) begin
                w_mem_we = 1'b1;
                w_waddr  = bus.addr;
                w_wdata  = bus.din;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_vld;
    logic              r_rd_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
            r_rd_vld  <= 1'b0;
            r_rd_err  <= 1'b0;
        end else begin
            r_rd_vld <= 1'b0;
            r_rd_err <= 1'b0;
            if (w_acc) begin
                r_rd_err <= !w_in_range;
                if (!bus.we) begin
                    r_rd_vld  <= 1'b1;
                    r_rd_data <= w_in_range ? r_mem[bus.addr] : '0;
                end
            end
        end
    end

`ifdef SRAM_OUT_REG_EN
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_vld;
    logic              r_out_err;

    // free-running stage: clr does not flush reads already accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data <= '0;
            r_out_vld  <= 1'b0;
            r_out_err  <= 1'b0;
        end else begin
            r_out_data <= r_rd_data;
            r_out_vld  <= r_rd_vld;
            r_out_err  <= r_rd_err;
        end
    end

    assign bus.dout       = r_out_data;
    assign bus.dout_valid = r_out_vld;
    assign bus.err        = r_out_err;
`else
    assign bus.dout       = r_rd_data;
    assign bus.dout_valid = r_rd_vld;
    assign bus.err        = r_rd_err;
`endif

    assign bus.busy = !w_idle;
endmodule

// File: tb/tb_sram_sync_param.sv
// Bench for sram_sync_param: a full-depth instance (32) and a partial-depth one (20).
module tb_sram_sync_param;
    localparam int DW      = 4;
    localparam int AW      = 5;
    localparam int DEPTH_A = 32;
    localparam int DEPTH_B = 20;
`ifdef SRAM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass  = 0;
    int   n_total = 0;

    logic [DW-1:0] mem_a [DEPTH_A];
    logic [DW-1:0] mem_b [DEPTH_B];

    sram_sync_param_if #(.DATA_W(DW), .ADDR_W(AW)) if_a ();
    sram_sync_param_if #(.DATA_W(DW), .ADDR_W(AW)) if_b ();

    sram_sync_param #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH_A)) u_a (
        .clk(clk), .rst(rst), .bus(if_a)
    );
    sram_sync_param #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH_B)) u_b (
        .clk(clk), .rst(rst), .bus(if_b)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        if_a.en = 1'b0; if_a.we = 1'b0; if_a.addr = '0; if_a.din = '0; if_a.clr = 1'b0;
        if_b.en = 1'b0; if_b.we = 1'b0; if_b.addr = '0; if_b.din = '0; if_b.clr = 1'b0;
    endtask

    // one access on A, outputs sampled when its result is due
    task automatic acc_a(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         output logic [DW-1:0] dout, output logic vld, output logic err);
        if_a.en = 1'b1; if_a.we = we; if_a.addr = a; if_a.din = d;
        tick;
        if_a.en = 1'b0; if_a.we = 1'b0;
        repeat (LAT - 1) tick;
        dout = if_a.dout; vld = if_a.dout_valid; err = if_a.err;
    endtask

    task automatic acc_b(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         output logic [DW-1:0] dout, output logic vld, output logic err);
        if_b.en = 1'b1; if_b.we = we; if_b.addr = a; if_b.din = d;
        tick;
        if_b.en = 1'b0; if_b.we = 1'b0;
        repeat (LAT - 1) tick;
        dout = if_b.dout; vld = if_b.dout_valid; err = if_b.err;
    endtask

    task automatic test_reset;
        logic [DW-1:0] d;
        logic v, e;
        int k, done_a, done_b;
        idle_inputs();
        rst = 1'b1;
        tick; tick;
        n_total++;
        if ({if_a.dout, if_a.dout_valid, if_a.err, if_a.busy} !== {DW'(0), 1'b0, 1'b0, 1'b1}) begin
            $display("FAIL reset_state got dout=%h vld=%b err=%b busy=%b exp 0/0/0/1",
                     if_a.dout, if_a.dout_valid, if_a.err, if_a.busy);
        end else n_pass++;
        rst = 1'b0;
        k = 0; done_a = 0; done_b = 0;
        while ((done_a == 0 || done_b == 0) && k < 200) begin
            tick; k++;
            if (!if_a.busy && done_a == 0) done_a = k;
            if (!if_b.busy && done_b == 0) done_b = k;
        end
        n_total++;
        if (done_a != DEPTH_A) $display("FAIL reset_sweep_a edges=%0d exp=%0d", done_a, DEPTH_A);
        else n_pass++;
        n_total++;
        if (done_b != DEPTH_B) $display("FAIL reset_sweep_b edges=%0d exp=%0d", done_b, DEPTH_B);
        else n_pass++;
        for (int i = 0; i < DEPTH_A; i++) mem_a[i] = '0;
        for (int i = 0; i < DEPTH_B; i++) mem_b[i] = '0;
        for (int i = 0; i < DEPTH_A; i++) begin
            acc_a(1'b0, AW'(i), '0, d, v, e);
            n_total++;
            if ({v, e, d} !== {1'b1, 1'b0, mem_a[i]})
                $display("FAIL reset_readback addr=%0d got v=%b e=%b d=%h exp 1/0/%h", i, v, e, d, mem_a[i]);
            else n_pass++;
        end
    endtask

    task automatic test_write_readback;
        logic [DW-1:0] d;
        logic v, e;
        int k;
        for (int i = 1; i <= 5; i++) begin
            acc_a(1'b1, AW'(i), DW'(i), d, v, e);
            mem_a[i] = DW'(i);
            n_total++;
            if ({v, e} !== 2'b00) $display("FAIL write_strobe addr=%0d got v=%b e=%b exp 0/0", i, v, e);
            else n_pass++;
        end
        if_a.we = 1'bx; if_a.addr = 'x; if_a.din = 'x;
        tick; tick;
        idle_inputs();
        for (int i = 1; i <= 5; i++) begin
            if_a.en = 1'b1; if_a.we = 1'b0; if_a.addr = AW'(i);
            tick;
            if_a.en = 1'b0;
            k = 1;
            while (!if_a.dout_valid && k < 6) begin tick; k++; end
            n_total++;
            if (k != LAT || if_a.dout !== mem_a[i])
                $display("FAIL readback addr=%0d got lat=%0d d=%h exp lat=%0d d=%h", i, k, if_a.dout, LAT, mem_a[i]);
            else n_pass++;
            tick;
            n_total++;
            if (if_a.dout_valid !== 1'b0) $display("FAIL valid_pulse addr=%0d got vld=%b exp 0", i, if_a.dout_valid);
            else n_pass++;
        end
        // top address of a full-depth RAM is in range
        acc_a(1'b1, AW'(31), 4'h6, d, v, e);
        mem_a[31] = 4'h6;
        acc_a(1'b0, AW'(31), '0, d, v, e);
        n_total++;
        if ({v, e, d} !== {1'b1, 1'b0, mem_a[31]})
            $display("FAIL full_depth_top got v=%b e=%b d=%h exp 1/0/%h", v, e, d, mem_a[31]);
        else n_pass++;
    endtask

    task automatic test_sweep_access;
        logic [DW-1:0] d;
        logic v, e;
        int n;
        logic strobe;
        acc_a(1'b1, AW'(3), 4'h5, d, v, e);
        mem_a[3] = 4'h5;
        if_a.clr = 1'b1;
        tick;
        if_a.clr = 1'b0;
        n = 0; strobe = 1'b0;
        while (if_a.busy && n < 200) begin
            n++;
            if_a.en = 1'b1; if_a.we = 1'b1; if_a.addr = AW'(3); if_a.din = 4'hF;
            tick;
            strobe = strobe | if_a.dout_valid | if_a.err;
        end
        idle_inputs();
        for (int i = 0; i < DEPTH_A; i++) mem_a[i] = '0;
        n_total++;
        if (n != DEPTH_A) $display("FAIL sweep_busy_len got=%0d exp=%0d", n, DEPTH_A);
        else n_pass++;
        n_total++;
        if (strobe !== 1'b0) $display("FAIL sweep_strobes got=%b exp 0", strobe);
        else n_pass++;
        acc_a(1'b0, AW'(3), '0, d, v, e);
        n_total++;
        if ({v, d} !== {1'b1, mem_a[3]}) $display("FAIL sweep_ignores_write got d=%h exp %h", d, mem_a[3]);
        else n_pass++;
    endtask

    task automatic test_clear_cmd;
        logic [DW-1:0] d;
        logic v, e;
        int n;
        for (int i = 0; i < DEPTH_A; i++) begin
            acc_a(1'b1, AW'(i), 4'hA, d, v, e);
            mem_a[i] = 4'hA;
        end
        if_a.clr = 1'b1; if_a.en = 1'b1; if_a.we = 1'b1; if_a.addr = AW'(7); if_a.din = 4'h5;
        tick;
        idle_inputs();
        n = 0;
        while (if_a.busy && n < 200) begin n++; tick; end
        for (int i = 0; i < DEPTH_A; i++) mem_a[i] = '0;
        n_total++;
        if (n != DEPTH_A) $display("FAIL clear_busy_len got=%0d exp=%0d", n, DEPTH_A);
        else n_pass++;
        for (int i = 0; i < DEPTH_A; i++) begin
            acc_a(1'b0, AW'(i), '0, d, v, e);
            n_total++;
            if ({v, e, d} !== {1'b1, 1'b0, mem_a[i]})
                $display("FAIL clear_readback addr=%0d got v=%b e=%b d=%h exp 1/0/%h", i, v, e, d, mem_a[i]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_op;
        logic [DW-1:0] d;
        logic v, e;
        int k, done;
        if_a.clr = 1'b1;
        tick;
        if_a.clr = 1'b0;
        repeat (10) tick;
        rst = 1'b1;
        tick;
        n_total++;
        if (if_a.busy !== 1'b1) $display("FAIL midsweep_rst_busy got=%b exp 1", if_a.busy);
        else n_pass++;
        rst = 1'b0;
        k = 0; done = 0;
        while (done == 0 && k < 200) begin tick; k++; if (!if_a.busy) done = k; end
        n_total++;
        if (done != DEPTH_A) $display("FAIL midsweep_restart edges=%0d exp=%0d", done, DEPTH_A);
        else n_pass++;
        for (int i = 0; i < DEPTH_A; i++) mem_a[i] = '0;
        for (int i = 0; i < DEPTH_B; i++) mem_b[i] = '0;

        acc_a(1'b1, AW'(2), 4'h9, d, v, e);
        mem_a[2] = 4'h9;
        if_a.en = 1'b1; if_a.we = 1'b0; if_a.addr = AW'(2);
        tick;
        if_a.en = 1'b0;
        rst = 1'b1;
        tick;
        n_total++;
        if ({if_a.dout_valid, if_a.err, if_a.dout} !== {1'b0, 1'b0, DW'(0)})
            $display("FAIL rst_inflight got v=%b e=%b d=%h exp 0/0/0", if_a.dout_valid, if_a.err, if_a.dout);
        else n_pass++;
        rst = 1'b0;
        k = 0; done = 0;
        while (done == 0 && k < 200) begin tick; k++; if (!if_a.busy) done = k; end
        n_total++;
        if (done != DEPTH_A || if_b.busy !== 1'b0)
            $display("FAIL rst_recover edges=%0d busy_b=%b exp %0d/0", done, if_b.busy, DEPTH_A);
        else n_pass++;
        for (int i = 0; i < DEPTH_A; i++) mem_a[i] = '0;
    endtask

    task automatic test_out_of_range;
        logic [DW-1:0] d;
        logic v, e;
        for (int i = 0; i < DEPTH_B; i++) begin
            mem_b[i] = DW'($urandom);
            acc_b(1'b1, AW'(i), mem_b[i], d, v, e);
        end
        acc_b(1'b0, AW'(25), '0, d, v, e);
        n_total++;
        if ({v, e, d} !== {1'b1, 1'b1, DW'(0)}) $display("FAIL oor_read got v=%b e=%b d=%h exp 1/1/0", v, e, d);
        else n_pass++;
        tick;
        n_total++;
        if ({if_b.dout_valid, if_b.err} !== 2'b00)
            $display("FAIL oor_read_pulse got v=%b e=%b exp 0/0", if_b.dout_valid, if_b.err);
        else n_pass++;
        acc_b(1'b1, AW'(20), 4'hF, d, v, e);
        n_total++;
        if ({v, e} !== 2'b01) $display("FAIL oor_write got v=%b e=%b exp 0/1", v, e);
        else n_pass++;
        tick;
        n_total++;
        if (if_b.err !== 1'b0) $display("FAIL oor_write_pulse got e=%b exp 0", if_b.err);
        else n_pass++;
        acc_b(1'b1, AW'(19), ~mem_b[19], d, v, e);
        mem_b[19] = ~mem_b[19];
        n_total++;
        if (e !== 1'b0) $display("FAIL last_in_range_write got e=%b exp 0", e);
        else n_pass++;
        for (int i = 0; i < DEPTH_B; i++) begin
            acc_b(1'b0, AW'(i), '0, d, v, e);
            n_total++;
            if ({v, e, d} !== {1'b1, 1'b0, mem_b[i]})
                $display("FAIL oor_intact addr=%0d got v=%b e=%b d=%h exp 1/0/%h", i, v, e, d, mem_b[i]);
            else n_pass++;
        end
    endtask

    // back-to-back random traffic on the partial-depth RAM
    task automatic test_random;
        logic [DW-1:0]   d, prev;
        logic            v, e;
        logic [DW+1:0]   q[$];
        logic [DW+1:0]   exp_o;
        logic            en, we;
        int              a;
        logic [DW-1:0]   din;
        acc_b(1'b0, AW'(0), '0, d, v, e);
        n_total++;
        if ({v, d} !== {1'b1, mem_b[0]}) $display("FAIL rand_seed_read got d=%h exp %h", d, mem_b[0]);
        else n_pass++;
        prev = mem_b[0];
        if (LAT == 2) q.push_back({1'b0, 1'b0, prev});
        for (int c = 0; c < 300; c++) begin
            en  = ($urandom_range(0, 3) != 0);
            we  = $urandom_range(0, 1) == 1;
            a   = $urandom_range(0, 31);
            din = DW'($urandom);
            if_b.en = en; if_b.we = we; if_b.addr = AW'(a); if_b.din = din;
            tick;
            if (!en) begin
                exp_o = {1'b0, 1'b0, prev};
            end else if (we) begin
                if (a < DEPTH_B) mem_b[a] = din;
                exp_o = {1'b0, a >= DEPTH_B, prev};
            end else begin
                prev  = (a < DEPTH_B) ? mem_b[a] : '0;
                exp_o = {1'b1, a >= DEPTH_B, prev};
            end
            q.push_back(exp_o);
            if (q.size() == LAT) begin
                exp_o = q.pop_front();
                n_total++;
                if ({if_b.dout_valid, if_b.err, if_b.dout} !== exp_o)
                    $display("FAIL random cyc=%0d got v/e/d=%b exp=%b", c,
                             {if_b.dout_valid, if_b.err, if_b.dout}, exp_o);
                else n_pass++;
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_write_readback();
        test_sweep_access();
        test_clear_cmd();
        test_reset_mid_op();
        test_out_of_range();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/sram_sync_param.md
Name: sram_sync_param

Overview:
Parametrised single-port synchronous static RAM: generalised data width, address width and depth.
- Adds a hardware clear sequencer that sweeps every word to INIT_VAL after reset or on command.
- Adds a read-valid strobe and out-of-range error detection.
- Drop-in storage block for register files and small buffers; sits directly on the local clk domain.

Parameters:
DATA_W, 4, word width in bits
ADDR_W, 5, address width in bits
DEPTH, 32, number of words implemented; must satisfy 1 <= DEPTH <= 2**ADDR_W
INIT_VAL, 0, DATA_W-bit value written to every word by the clear sweep

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
en  input  1  access request; sampled on rising clk
we  input  1  1 = write, 0 = read; qualified by en
addr  input  ADDR_W  word address
din  input  DATA_W  write data
clr  input  1  single-cycle request to start a clear sweep
dout  output  DATA_W  registered read data
dout_valid  output  1  one-cycle strobe: dout holds data from a completed read
busy  output  1  clear sweep in progress; accesses ignored
err  output  1  one-cycle strobe: accepted access had addr >= DEPTH

Behaviour:
- One clock, reset is synchronous and active-high; clock port clk, reset port rst.
- Reset (rst=1 at an edge): state=CLEAR, sweep pointer=0, dout=0, dout_valid=0, err=0, busy=1. No memory writes occur while rst=1.
- FSM states: CLEAR, IDLE.
- CLEAR state:
  - Each edge with rst=0 writes INIT_VAL to mem[ptr] and increments ptr.
  - On the edge that writes ptr=DEPTH-1: next state IDLE, busy=0 from that edge.
  - Total sweep is exactly DEPTH edges after rst deasserts.
  - en, we and clr are ignored. dout_valid=0 and err=0 throughout.
- IDLE state, clr=1:
  - Next state CLEAR, ptr=0, busy=1.
  - Any en on the same edge is ignored; clr has priority.
- IDLE state, en=1, we=1, addr<DEPTH: mem[addr]<=din. dout unchanged, dout_valid=0.
- IDLE state, en=1, we=0, addr<DEPTH: dout<=mem[addr] and dout_valid<=1 on the same edge. Latency is 1 edge.
- Read of an address written on an earlier edge returns the new data. There is no same-edge read-during-write on a single port.
- Out-of-range access (en=1, addr>=DEPTH):
  - Writes are dropped; reads set dout<=0 and dout_valid<=1.
  - err<=1 for one cycle in both cases.
  - err is never set when DEPTH=2**ADDR_W.
- en=0: dout holds its last value; dout_valid=0, err=0.
- X on addr or din with en=0 must not corrupt memory.
- Reset mid-sweep restarts the sweep at address 0.
- Reset mid-operation discards any in-flight read: dout_valid=0.
- ptr is ADDR_W bits wide. The sweep terminates on DEPTH-1 rather than on ptr wrap, so non-power-of-two DEPTH is supported.

Optional Feature:
- Macro SRAM_OUT_REG_EN, defined:
  - Adds an output pipeline register after the array read.
  - dout, dout_valid and err all arrive 2 edges after the accepting edge and stay aligned.
  - rst clears both stages.
  - clr flushes nothing: reads accepted before clr still complete.
- Macro not defined: latency 1 as specified above.

Test Plan:
- Reset-to-ready: rst=1 for 2 cycles, then rst=0 -> busy=1 for exactly 32 edges then 0; all 32 addresses read back 4'h0; dout=0 and dout_valid=0 during reset.
- Write/read-back: write addr 1..5 with din 1..5, then en=0 with addr/din=X, then read 1..5 -> dout=1..5, one dout_valid pulse each, 1-cycle latency (2 with SRAM_OUT_REG_EN); X cycle leaves memory intact.
- Accesses during sweep: drive en=1, we=1, addr=3, din=4'hF while busy=1 -> after sweep, read addr 3 returns 4'h0.
- Clear command: fill addr 0..31 with 4'hA, pulse clr with a simultaneous en write to addr 7 -> busy 32 cycles, addr 7 and all other words read 4'h0.
- Reset mid-sweep: assert rst 10 edges into a clr sweep -> busy stays 1, sweep completes exactly 32 edges after rst deasserts.
- Out-of-range: DEPTH=20, read addr 25 and write addr 20 -> err pulses once per access; read gives dout=0 with dout_valid=1; mem[0..19] unchanged; addr 19 accesses give err=0.
